// File: rtl/float_pkg.sv
// Shared types for the float packing path: class codes, default field widths,
// the canonical 32-bit NaN and the pack-control helper.
package float_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_SIG_W = 23;
    localparam logic [31:0] CANON_NAN_32 = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ZERO    = 3'd0,
        SUBNORM = 3'd1,
        NORMAL  = 3'd2,
        INF     = 3'd3,
        QNAN    = 3'd4,
        SNAN    = 3'd5
    } float_class_e;

    typedef enum logic [1:0] {
        PACK_PASS  = 2'd0,
        PACK_ZERO  = 2'd1,
        PACK_CANON = 2'd2
    } pack_sel_e;

    typedef struct packed {
        pack_sel_e    sel;
        float_class_e cls;
    } pack_ctl_t;

    // Decides how a classified value is packed and which class is reported
    // alongside the packed word.
    function automatic pack_ctl_t pack_control(input float_class_e cls,
                                               input logic ftz,
                                               input logic canon_nan);
        pack_ctl_t ctl;
        ctl.sel = PACK_PASS;
        ctl.cls = cls;
        if (ftz && cls == SUBNORM) begin
            ctl.sel = PACK_ZERO;
            ctl.cls = ZERO;
        end else if (canon_nan && (cls == QNAN || cls == SNAN)) begin
            ctl.sel = PACK_CANON;
            ctl.cls = QNAN;
        end
        return ctl;
    endfunction

endpackage

// File: rtl/float_classify.sv
// Combinational IEEE-754 classifier: biased exponent + fraction -> class code.
module float_classify
    import float_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int SIG_W = DEF_SIG_W
) (
    input  logic [EXP_W-1:0] exponent,
    input  logic [SIG_W-1:0] significand,
    output float_class_e     cls
);

    always_comb begin
        cls = NORMAL;
        if (exponent == '0) begin
            cls = (significand == '0) ? ZERO : SUBNORM;
        end else if (exponent == '1) begin
            if (significand == '0)
                cls = INF;
            else if (significand[SIG_W-1])
                cls = QNAN;
            else
                cls = SNAN;
        end
    end

endmodule

// File: rtl/float_pack_stage.sv
// Two-stage classify/pack pipeline producing IEEE-754 words.
// Optional FLOAT_PACK_STATS_EN adds saturating NaN/INF output-handshake counters.
module float_pack_stage
    import float_pkg::*;
#(
    parameter int EXP_W     = DEF_EXP_W,
    parameter int SIG_W     = DEF_SIG_W,
    parameter bit FTZ       = 1'b0,
    parameter bit CANON_NAN = 1'b1,
    localparam int W        = 1 + EXP_W + SIG_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic             io_in_sign,
    input  logic [EXP_W-1:0] io_in_exponent,
    input  logic [SIG_W-1:0] io_in_significand,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [W-1:0]     io_out_bits,
    output logic [2:0]       io_out_class
`ifdef FLOAT_PACK_STATS_EN
    ,
    output logic [15:0]      io_stat_nan_cnt,
    output logic [15:0]      io_stat_inf_cnt
`endif
);

    // Handshake: a beat moves when valid && ready at a rising edge. Valid is
    // driven from registers only; ready is a combinational chain from the
    // output back to the input so a full pipe still advances every cycle.
    logic             s1_valid;
    logic             s1_sign;
    logic [EXP_W-1:0] s1_exp;
    logic [SIG_W-1:0] s1_sig;
    float_class_e     s1_class;
    float_class_e     in_class;

    logic             s2_valid;
    logic             s2_ready;
    logic [W-1:0]     s2_bits;
    float_class_e     s2_class;

    pack_ctl_t        ctl;
    logic [W-1:0]     s1_word;

    assign s2_ready    = !s2_valid || io_out_ready;
    assign io_in_ready = !s1_valid || s2_ready;

    float_classify #(
        .EXP_W(EXP_W),
        .SIG_W(SIG_W)
    ) u_classify (
        .exponent   (io_in_exponent),
        .significand(io_in_significand),
        .cls        (in_class)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_sig   <= '0;
            s1_class <= ZERO;
        end else if (io_in_ready) begin
            s1_valid <= io_in_valid;
            if (io_in_valid) begin
                s1_sign  <= io_in_sign;
                s1_exp   <= io_in_exponent;
                s1_sig   <= io_in_significand;
                s1_class <= in_class;
            end
        end
    end

    assign ctl = pack_control(s1_class, FTZ, CANON_NAN);

    always_comb begin
        s1_word = {s1_sign, s1_exp, s1_sig};
        case (ctl.sel)
            PACK_ZERO:  s1_word = {s1_sign, {(W-1){1'b0}}};
            PACK_CANON: s1_word = {1'b0, {EXP_W{1'b1}}, 1'b1, {(SIG_W-1){1'b0}}};
            default:    s1_word = {s1_sign, s1_exp, s1_sig};
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_bits  <= '0;
            s2_class <= ZERO;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_bits  <= s1_word;
                s2_class <= ctl.cls;
            end
        end
    end

    assign io_out_valid = s2_valid;
    assign io_out_bits  = s2_bits;
    assign io_out_class = s2_class;

`ifdef FLOAT_PACK_STATS_EN
    // NaN statistics count the class seen before canonicalisation.
    float_class_e s2_raw_class;
    logic         out_fire;

    assign out_fire = s2_valid && io_out_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            s2_raw_class <= ZERO;
        end else if (s2_ready && s1_valid) begin
            s2_raw_class <= s1_class;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            io_stat_nan_cnt <= 16'h0000;
            io_stat_inf_cnt <= 16'h0000;
        end else if (out_fire) begin
            if ((s2_raw_class == QNAN || s2_raw_class == SNAN) && io_stat_nan_cnt != 16'hFFFF)
                io_stat_nan_cnt <= io_stat_nan_cnt + 16'h0001;
            if (s2_raw_class == INF && io_stat_inf_cnt != 16'hFFFF)
                io_stat_inf_cnt <= io_stat_inf_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_float_pack_stage.sv
// Bench for float_pack_stage: two instances (FTZ=0 and FTZ=1) share stimulus
// and are checked against a behavioural IEEE-754 packing model.
module tb_float_pack_stage;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready_a, in_ready_b;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [22:0] in_sig;
    logic        out_ready;
    logic        out_valid_a, out_valid_b;
    logic [31:0] bits_a, bits_b;
    logic [2:0]  cls_a, cls_b;
`ifdef FLOAT_PACK_STATS_EN
    logic [15:0] nan_a, inf_a, nan_b, inf_b;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt = 0;
    bit mon_en = 1'b1;

    logic [34:0] exp_a_q[$];
    logic [34:0] exp_b_q[$];
    logic [34:0] got_a_q[$];
    logic [34:0] got_b_q[$];
    int          got_a_cyc[$];

    float_pack_stage #(.FTZ(1'b0), .CANON_NAN(1'b1)) dut_a (
        .clock(clock), .reset(reset),
        .io_in_valid(in_valid), .io_in_ready(in_ready_a),
        .io_in_sign(in_sign), .io_in_exponent(in_exp), .io_in_significand(in_sig),
        .io_out_valid(out_valid_a), .io_out_ready(out_ready),
        .io_out_bits(bits_a), .io_out_class(cls_a)
`ifdef FLOAT_PACK_STATS_EN
        , .io_stat_nan_cnt(nan_a), .io_stat_inf_cnt(inf_a)
`endif
    );

    float_pack_stage #(.FTZ(1'b1), .CANON_NAN(1'b1)) dut_b (
        .clock(clock), .reset(reset),
        .io_in_valid(in_valid), .io_in_ready(in_ready_b),
        .io_in_sign(in_sign), .io_in_exponent(in_exp), .io_in_significand(in_sig),
        .io_out_valid(out_valid_b), .io_out_ready(out_ready),
        .io_out_bits(bits_b), .io_out_class(cls_b)
`ifdef FLOAT_PACK_STATS_EN
        , .io_stat_nan_cnt(nan_b), .io_stat_inf_cnt(inf_b)
`endif
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        exp_a_q.delete(); exp_b_q.delete();
        got_a_q.delete(); got_b_q.delete(); got_a_cyc.delete();
    endtask

    // Reference model: class codes 0 ZERO,1 SUBNORM,2 NORMAL,3 INF,4 QNAN,5 SNAN.
    function automatic logic [34:0] model(input bit ftz, input logic s,
                                          input logic [7:0] e, input logic [22:0] f);
        logic [2:0]  c;
        logic [31:0] w;
        if (e == 8'd0)        c = (f == 23'd0) ? 3'd0 : 3'd1;
        else if (e == 8'd255) c = (f == 23'd0) ? 3'd3 : ((f >= 23'h400000) ? 3'd4 : 3'd5);
        else                  c = 3'd2;
        w = {s, e, f};
        if (ftz && c == 3'd1) begin
            w = s ? 32'h8000_0000 : 32'h0000_0000;
            c = 3'd0;
        end
        if (c == 3'd4 || c == 3'd5) begin
            w = 32'h7FC0_0000;
            c = 3'd4;
        end
        return {c, w};
    endfunction

    // monitor: record every output handshake that will complete at the next edge
    always @(negedge clock) begin
        if (mon_en && reset && out_ready) begin
            if (out_valid_a) begin
                got_a_q.push_back({cls_a, bits_a});
                got_a_cyc.push_back(cyc);
            end
            if (out_valid_b) got_b_q.push_back({cls_b, bits_b});
        end
    end

    // driver: present one item and hold it until accepted
    task automatic send(input logic s, input logic [7:0] e, input logic [22:0] f);
        bit acc;
        int n;
        in_valid = 1'b1; in_sign = s; in_exp = e; in_sig = f;
        acc = 1'b0; n = 0;
        while (!acc && n < 200) begin
            @(negedge clock);
            acc = in_ready_a;
            @(posedge clock); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end else begin
            acc_cnt++;
            exp_a_q.push_back(model(1'b0, s, e, f));
            exp_b_q.push_back(model(1'b1, s, e, f));
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        out_ready = 1'b1;
        while ((got_a_q.size() < exp_a_q.size() || got_b_q.size() < exp_b_q.size()) && n < 500) begin
            @(posedge clock); #1;
            n++;
        end
        repeat (3) begin @(posedge clock); #1; end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d items, required %0d", got_a_q.size(), exp_a_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_sig = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", out_valid_a); end
        checks++; if (bits_a !== 32'h0) begin errors++; $display("FAIL reset_bits: got %h required 0", bits_a); end
        checks++; if (cls_a !== 3'd0) begin errors++; $display("FAIL reset_class: got %0d required 0", cls_a); end
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready_a); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(1'b1, 8'h0A, 23'h80);
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL basic_early: out_valid %b one cycle after accept, required 0", out_valid_a); end
        @(posedge clock); #1;
        checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL basic_latency: out_valid %b two cycles after accept, required 1", out_valid_a); end
        checks++; if (bits_a !== 32'h8500_0080) begin errors++; $display("FAIL basic_bits: got %h required 85000080", bits_a); end
        checks++; if (cls_a !== 3'd2) begin errors++; $display("FAIL basic_class: got %0d required 2", cls_a); end
        wait_drain();
        exp_a_q.delete(); exp_b_q.delete(); got_a_q.delete(); got_b_q.delete(); got_a_cyc.delete();
    endtask

    task automatic test_specials();
        logic [7:0]  te[6]  = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00};
        logic [22:0] tf[6]  = '{23'h0, 23'h1, 23'h0, 23'h5, 23'h400123, 23'h5};
        logic        ts[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [34:0] ra[6]  = '{{3'd3, 32'h7F80_0000}, {3'd4, 32'h7FC0_0000}, {3'd0, 32'h8000_0000},
                                {3'd1, 32'h8000_0005}, {3'd4, 32'h7FC0_0000}, {3'd1, 32'h0000_0005}};
        logic [34:0] rb[6]  = '{{3'd3, 32'h7F80_0000}, {3'd4, 32'h7FC0_0000}, {3'd0, 32'h8000_0000},
                                {3'd0, 32'h8000_0000}, {3'd4, 32'h7FC0_0000}, {3'd0, 32'h0000_0000}};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(ts[i], te[i], tf[i]);
        wait_drain();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got_a_q[i] !== ra[i]) begin errors++; $display("FAIL special_ftz0[%0d]: got %h required %h", i, got_a_q[i], ra[i]); end
            checks++;
            if (got_b_q[i] !== rb[i]) begin errors++; $display("FAIL special_ftz1[%0d]: got %h required %h", i, got_b_q[i], rb[i]); end
        end
        exp_a_q.delete(); exp_b_q.delete(); got_a_q.delete(); got_b_q.delete(); got_a_cyc.delete();
    endtask

    task automatic test_random();
        bit done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    logic [7:0]  e;
                    logic [22:0] f;
                    case ($urandom_range(0, 4))
                        0:       e = 8'h00;
                        1:       e = 8'hFF;
                        default: e = 8'($urandom_range(1, 254));
                    endcase
                    case ($urandom_range(0, 3))
                        0:       f = 23'h0;
                        1:       f = 23'h1;
                        2:       f = 23'h400000 | 23'($urandom_range(0, 23'h3FFFFF));
                        default: f = 23'($urandom_range(0, 23'h7FFFFF));
                    endcase
                    send(1'($urandom_range(0, 1)), e, f);
                    if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clock); #1;
                end
            end
        join
        wait_drain();
        checks++;
        if (got_a_q.size() != exp_a_q.size() || got_b_q.size() != exp_b_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d/%0d items, required %0d", got_a_q.size(), got_b_q.size(), exp_a_q.size());
        end
        for (int i = 0; i < exp_a_q.size(); i++) begin
            checks++;
            if (got_a_q[i] !== exp_a_q[i]) begin errors++; $display("FAIL random_ftz0[%0d]: got %h required %h", i, got_a_q[i], exp_a_q[i]); end
            checks++;
            if (got_b_q[i] !== exp_b_q[i]) begin errors++; $display("FAIL random_ftz1[%0d]: got %h required %h", i, got_b_q[i], exp_b_q[i]); end
        end
        exp_a_q.delete(); exp_b_q.delete(); got_a_q.delete(); got_b_q.delete(); got_a_cyc.delete();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        acc_cnt = 0;
        fork
            for (int k = 1; k <= 5; k++) send(1'b0, 8'(k), 23'(k));
            begin
                repeat (6) begin @(posedge clock); #1; end
                checks++; if (acc_cnt != 2) begin errors++; $display("FAIL bp_accepted: got %0d required 2", acc_cnt); end
                checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b required 0", in_ready_a); end
                checks++; if (out_valid_a !== 1'b1 || bits_a !== 32'h0080_0001) begin
                    errors++; $display("FAIL bp_hold: valid %b bits %h required 1 00800001", out_valid_a, bits_a);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        checks++;
        if (got_a_q.size() != 5) begin errors++; $display("FAIL bp_count: got %0d required 5", got_a_q.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_a_q[i] !== exp_a_q[i]) begin errors++; $display("FAIL bp_order[%0d]: got %h required %h", i, got_a_q[i], exp_a_q[i]); end
            checks++;
            if (got_a_cyc[i] != got_a_cyc[0] + i) begin errors++; $display("FAIL bp_gap[%0d]: cycle %0d required %0d", i, got_a_cyc[i], got_a_cyc[0] + i); end
        end
        exp_a_q.delete(); exp_b_q.delete(); got_a_q.delete(); got_b_q.delete(); got_a_cyc.delete();
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        send(1'b0, 8'h40, 23'h123);
        send(1'b1, 8'h41, 23'h456);
        checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL rst_full: in_ready %b required 0", in_ready_a); end
        do_reset();
        checks++; if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b%b required 00", out_valid_a, out_valid_b); end
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b required 1", in_ready_a); end
        checks++; if (bits_a !== 32'h0 || cls_a !== 3'd0) begin errors++; $display("FAIL rst_out: bits %h class %0d required 0 0", bits_a, cls_a); end
        out_ready = 1'b1;
        repeat (5) begin @(posedge clock); #1; end
        checks++; if (got_a_q.size() != 0 || got_b_q.size() != 0) begin
            errors++; $display("FAIL rst_stale: got %0d/%0d items required 0", got_a_q.size(), got_b_q.size());
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++)
            send(1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom_range(0, 23'h7FFFFF)));
        wait_drain();
        checks++;
        if (got_a_q.size() != 20) begin errors++; $display("FAIL b2b_count: got %0d required 20", got_a_q.size()); end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (got_a_q[i] !== exp_a_q[i] || got_a_cyc[i] != got_a_cyc[0] + i) begin
                errors++; $display("FAIL b2b[%0d]: got %h at cycle %0d required %h at %0d",
                                   i, got_a_q[i], got_a_cyc[i], exp_a_q[i], got_a_cyc[0] + i);
            end
        end
        exp_a_q.delete(); exp_b_q.delete(); got_a_q.delete(); got_b_q.delete(); got_a_cyc.delete();
    endtask

`ifdef FLOAT_PACK_STATS_EN
    task automatic test_stats();
        do_reset();
        checks++; if (nan_a !== 16'h0 || inf_a !== 16'h0) begin errors++; $display("FAIL stat_reset: nan %h inf %h required 0 0", nan_a, inf_a); end
        send(1'b0, 8'hFF, 23'h1);
        send(1'b1, 8'hFF, 23'h2);
        send(1'b0, 8'hFF, 23'h400000);
        wait_drain();
        checks++; if (nan_a !== 16'd3) begin errors++; $display("FAIL stat_nan: got %0d required 3", nan_a); end
        do_reset();
        mon_en = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'hFF; in_sig = 23'h0;
        repeat (100) @(posedge clock);
        #1; in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (inf_a !== 16'd100) begin errors++; $display("FAIL stat_inf_100: got %0d required 100", inf_a); end
        in_valid = 1'b1;
        repeat (70000) @(posedge clock);
        #1; in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (inf_a !== 16'hFFFF) begin errors++; $display("FAIL stat_inf_sat: got %h required ffff", inf_a); end
        checks++; if (nan_a !== 16'h0) begin errors++; $display("FAIL stat_nan_zero: got %h required 0", nan_a); end
        mon_en = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_specials();
        test_backpressure();
        test_random();
        test_reset_midflight();
        test_back_to_back();
`ifdef FLOAT_PACK_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
